seq_restoring_divider: RTL and testbench

- Sequential unsigned restoring divider, one quotient bit per clock; the divide-direction counterpart to the array multiplier datapath.
- Iterates a shift/trial-subtract/restore loop over an internal borrow-ripple subtractor.
- Sits behind the Tiny Tapeout I/O wrapper: dividend/divisor come in on a start strobe, quotient/remainder come out with a done pulse.

---
 rtl/seq_restoring_divider_pkg.sv | 14 +
 rtl/seq_restoring_divider_nbit_subtractor.sv | 29 ++
 rtl/seq_restoring_divider.sv | 171 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   - DIV_DEFAULT_W : default operand width
//   - div_state_e   : controller state encoding (IDLE / RUN / FIN)
package seq_restoring_divider_pkg;

    localparam int DIV_DEFAULT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_restoring_divider_nbit_subtractor.sv
// Combinational W-bit ripple-borrow subtractor: d_o = a_i - b_i.
// Ports:
//   a_i      : minuend
//   b_i      : subtrahend
//   d_o      : difference (modulo 2^W)
//   borrow_o : 1 when a_i < b_i (unsigned)
module nbit_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] d_o,
    output logic         borrow_o
);

    logic [W:0] brw_s;

    // Borrow ripples from bit 0 upward, one full-subtractor cell per bit.
    always_comb begin
        brw_s    = '0;
        d_o      = '0;
        for (int i = 0; i < W; i++) begin
            d_o[i]     = a_i[i] ^ b_i[i] ^ brw_s[i];
            brw_s[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw_s[i]);
        end
        borrow_o = brw_s[W];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : request strobe, accepted only while busy is low
//   dividend     : unsigned dividend, captured on an accepted start
//   divisor      : unsigned divisor, captured on an accepted start
//   quotient     : result quotient, held from done until the next accepted start
//   remainder    : result remainder, same validity as quotient
//   busy         : high while an operation is in flight
//   done         : one-cycle pulse when new results are presented
//   div_by_zero  : high with results when the captured divisor was zero
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = DIV_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    div_state_e    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [N-1:0]  r_q,         r_d;        // partial remainder
    logic [N-1:0]  q_q,         q_d;        // dividend shifting out / quotient shifting in
    logic [N-1:0]  dvs_q,       dvs_d;      // captured divisor
    logic          zero_q,      zero_d;     // captured divisor was zero
    logic [N-1:0]  quotient_q,  quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          dbz_q,       dbz_d;

    logic [N:0]    trial_s;
    logic [N:0]    diff_s;
    logic          borrow_s;
    logic [N-1:0]  r_next_s;
    logic [N-1:0]  q_next_s;
    logic          diff_msb_unused_s;

    // Trial operand: remainder shifted left with the next dividend bit.
    assign trial_s = {r_q, q_q[N-1]};

    nbit_subtractor #(
        .W (N + 1)
    ) u_sub (
        .a_i      (trial_s),
        .b_i      ({1'b0, dvs_q}),
        .d_o      (diff_s),
        .borrow_o (borrow_s)
    );

    // R < divisor is invariant, so a non-borrowing difference always fits in N bits.
    assign diff_msb_unused_s = diff_s[N];

    // One restoring step: keep the difference if it fits, otherwise restore.
    always_comb begin
        if (borrow_s) begin
            r_next_s = trial_s[N-1:0];
        end else begin
            r_next_s = diff_s[N-1:0];
        end
        q_next_s = {q_q[N-2:0], ~borrow_s};
    end

    // Controller next-state and datapath load decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    dvs_d   = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    cnt_d   = CW'(N - 1);
                    zero_d  = (divisor == '0);
                    dbz_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (zero_q) begin
                    // Zero divisor: skip iteration; q_q still holds the dividend.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_FIN;
                end else begin
                    r_d = r_next_s;
                    q_d = q_next_s;
                    if (cnt_q == '0) begin
                        quotient_d  = q_next_s;
                        remainder_d = r_next_s;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = ST_FIN;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [7:0] divisor = 8'd0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    seq_restoring_divider #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("done_single_cycle", int'(prev_done), 0);
            chk("busy_low_at_done", int'(busy), 0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", int'(quotient), int'(e.q));
                chk("remainder", int'(remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                chk("done_cycle", cyc, e.cyc);
            end
        end
        prev_done = done;
    end

    // Issue a one-cycle start; optionally register the expected result.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input bit expect_done);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (expect_done) begin
            e.q   = eq;
            e.r   = er;
            e.dz  = edz;
            e.cyc = cyc + 1 + ((b == 8'd0) ? 1 : 8);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty.
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        bit   seen;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation with busy check
        issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
        chk("busy_after_start", int'(busy), 1);
        drain();
        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
        drain();
        issue(8'd3, 8'd10, 8'd0, 8'd3, 1'b0, 1'b1);
        drain();
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1);
        drain();

        // Divide by zero, then a normal op clears the flag
        issue(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b1);
        drain();
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1);
        drain();

        // Start while busy is ignored; outputs hold the old result during RUN
        issue(8'd100, 8'd9, 8'd11, 8'd1, 1'b0, 1'b1);
        chk("hold_quotient_in_run", int'(quotient), 3);
        chk("hold_remainder_in_run", int'(remainder), 0);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("held_quotient_idle", int'(quotient), 11);
        chk("held_remainder_idle", int'(remainder), 1);

        // Asynchronous reset mid-operation
        issue(8'd200, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_before_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_abort_busy", int'(busy), 0);
        issue(8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 1'b1);
        drain();

        // Back-to-back with start held high
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd60;
        divisor  = 8'd7;
        e.q = 8'd8; e.r = 8'd4; e.dz = 1'b0; e.cyc = cyc + 9;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_first_done_seen", int'(seen), 1);
        divisor = 8'd6;
        e.q = 8'd10; e.r = 8'd0; e.dz = 1'b0; e.cyc = cyc + 9;
        sb.push_back(e);
        @(negedge clk);
        chk("b2b_busy_restart", int'(busy), 1);
        start = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
